// File: rtl/pip_mem_pkg.sv
// rtl/pip_mem_pkg.sv - shared types and defaults for the unified memory port arbiter
package pip_mem_pkg;

   localparam int AW_DEF      = 32;
   localparam int DW_DEF      = 32;
   localparam int TIMEOUT_DEF = 15;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_ACC  = 2'd1,
      MEM_ACC = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - pipeline-side and memory-side signals of the port arbiter
interface mem_port_arbiter_if
   import pip_mem_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
);
   // instruction fetch requester
   logic          IF_Req;
   logic [AW-1:0] IF_Addr;
   logic          IF_Flush;
   logic          IF_Ack;
   logic          IF_Valid;
   logic [DW-1:0] IF_RData;
   // MEM stage requester
   logic          MEM_Req;
   logic          MEM_Wr;
   logic [AW-1:0] MEM_Addr;
   logic [DW-1:0] MEM_WData;
   logic          MEM_Ack;
   logic [DW-1:0] MEM_RData;
   // memory model
   logic          Mem_Req;
   logic          Mem_Wr;
   logic [AW-1:0] Mem_Addr;
   logic [DW-1:0] Mem_WData;
   logic          Mem_Ready;
   logic [DW-1:0] Mem_RData;
   // pipeline control
   logic          PCWre;
   logic          Pipe_Stall;
   logic          Bus_Err;

   // arbiter view
   modport slave (
      input  IF_Req, IF_Addr, IF_Flush,
      output IF_Ack, IF_Valid, IF_RData,
      input  MEM_Req, MEM_Wr, MEM_Addr, MEM_WData,
      output MEM_Ack, MEM_RData,
      output Mem_Req, Mem_Wr, Mem_Addr, Mem_WData,
      input  Mem_Ready, Mem_RData,
      output PCWre, Pipe_Stall, Bus_Err
   );

   // pipeline and memory environment view
   modport master (
      output IF_Req, IF_Addr, IF_Flush,
      input  IF_Ack, IF_Valid, IF_RData,
      output MEM_Req, MEM_Wr, MEM_Addr, MEM_WData,
      input  MEM_Ack, MEM_RData,
      input  Mem_Req, Mem_Wr, Mem_Addr, Mem_WData,
      output Mem_Ready, Mem_RData,
      input  PCWre, Pipe_Stall, Bus_Err
   );

endinterface

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry fetched instruction holding register
module fetch_hold_buf
   import pip_mem_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic          load,
   input  logic [DW-1:0] load_data,
   input  logic          consume,
   input  logic          flush,
   output logic          valid,
   output logic [DW-1:0] rdata
);

   logic          valid_q, valid_d;
   logic [DW-1:0] rdata_q, rdata_d;

   // flush beats a load (the word belongs to the old path); a load beats a consume
   always_comb begin
      valid_d = valid_q;
      rdata_d = rdata_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         rdata_d = load_data;
      end else if (consume) begin
         valid_d = 1'b0;
      end
   end

   // buffer registers
   always_ff @(posedge CLK) begin
      if (Reset) begin
         valid_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         valid_q <= valid_d;
         rdata_q <= rdata_d;
      end
   end

   assign valid = valid_q;
   assign rdata = rdata_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and the MEM stage
module mem_port_arbiter
   import pip_mem_pkg::*;
#(
   parameter int AW      = AW_DEF,
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input logic                CLK,
   input logic                Reset,
   mem_port_arbiter_if.slave  bus
);

   localparam int CW = $clog2(TIMEOUT + 1);

   arb_state_e    state_q, state_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_wr_q, mem_wr_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          if_ack_q, if_ack_d;
   logic          mem_ack_q, mem_ack_d;
   logic [DW-1:0] mem_rdata_q, mem_rdata_d;
   logic [DW-1:0] if_word_q, if_word_d;
   logic          flush_pend_q, flush_pend_d;
   logic          bus_err_q, bus_err_d;

   logic          if_valid;
   logic [DW-1:0] if_rdata;
   logic          pipe_stall;
   logic          pcwre;
   logic          mem_go;
   logic          if_go;
   logic [DW-1:0] acc_rdata;

   assign pipe_stall = bus.MEM_Req & ~mem_ack_q;
   assign pcwre      = if_valid & ~pipe_stall;
   // a requester in its Ack cycle is still holding Req for the finished access
   assign mem_go     = bus.MEM_Req & ~mem_ack_q;
   assign if_go      = bus.IF_Req & ~if_ack_q & ~if_valid;

   // grant, hold the bus registers while waiting on Mem_Ready, complete or time out
   always_comb begin
      state_d      = state_q;
      mem_req_d    = mem_req_q;
      mem_wr_d     = mem_wr_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      cnt_d        = cnt_q;
      if_ack_d     = 1'b0;
      mem_ack_d    = 1'b0;
      mem_rdata_d  = mem_rdata_q;
      if_word_d    = if_word_q;
      flush_pend_d = flush_pend_q;
      bus_err_d    = bus_err_q;
      acc_rdata    = '0;
      unique case (state_q)
         IDLE: begin
            if (mem_go) begin
               state_d     = MEM_ACC;
               mem_req_d   = 1'b1;
               mem_wr_d    = bus.MEM_Wr;
               mem_addr_d  = bus.MEM_Addr;
               mem_wdata_d = bus.MEM_WData;
               cnt_d       = '0;
            end else if (if_go) begin
               state_d      = IF_ACC;
               mem_req_d    = 1'b1;
               mem_wr_d     = 1'b0;
               mem_addr_d   = bus.IF_Addr;
               mem_wdata_d  = '0;
               cnt_d        = '0;
               flush_pend_d = bus.IF_Flush;
            end
         end
         IF_ACC, MEM_ACC: begin
            if (state_q == IF_ACC && bus.IF_Flush) begin
               flush_pend_d = 1'b1;
            end
            if (!bus.Mem_Ready) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (bus.Mem_Ready || cnt_d == CW'(TIMEOUT)) begin
               acc_rdata = bus.Mem_Ready ? bus.Mem_RData : '0;
               state_d   = IDLE;
               mem_req_d = 1'b0;
               mem_wr_d  = 1'b0;
               if (!bus.Mem_Ready) begin
                  bus_err_d = 1'b1;
               end
               if (state_q == MEM_ACC) begin
                  mem_ack_d   = 1'b1;
                  mem_rdata_d = acc_rdata;
               end else begin
                  if_ack_d  = 1'b1;
                  if_word_d = acc_rdata;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state, bus and status registers
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q      <= IDLE;
         mem_req_q    <= 1'b0;
         mem_wr_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cnt_q        <= '0;
         if_ack_q     <= 1'b0;
         mem_ack_q    <= 1'b0;
         mem_rdata_q  <= '0;
         if_word_q    <= '0;
         flush_pend_q <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_wr_q     <= mem_wr_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         cnt_q        <= cnt_d;
         if_ack_q     <= if_ack_d;
         mem_ack_q    <= mem_ack_d;
         mem_rdata_q  <= mem_rdata_d;
         if_word_q    <= if_word_d;
         flush_pend_q <= flush_pend_d;
         bus_err_q    <= bus_err_d;
      end
   end

   fetch_hold_buf #(.DW(DW)) u_fetch_hold_buf (
      .CLK       (CLK),
      .Reset     (Reset),
      .load      (if_ack_q & ~flush_pend_q),
      .load_data (if_word_q),
      .consume   (pcwre),
      .flush     (bus.IF_Flush),
      .valid     (if_valid),
      .rdata     (if_rdata)
   );

   assign bus.IF_Ack     = if_ack_q;
   assign bus.IF_Valid   = if_valid;
   assign bus.IF_RData   = if_rdata;
   assign bus.MEM_Ack    = mem_ack_q;
   assign bus.MEM_RData  = mem_rdata_q;
   assign bus.Mem_Req    = mem_req_q;
   assign bus.Mem_Wr     = mem_wr_q;
   assign bus.Mem_Addr   = mem_addr_q;
   assign bus.Mem_WData  = mem_wdata_q;
   assign bus.PCWre      = pcwre;
   assign bus.Pipe_Stall = pipe_stall;
   assign bus.Bus_Err    = bus_err_q;

endmodule
